// File: rtl/flash_loader.sv
// Boot-time copier: moves the enabled flash regions (MegaROM, Nextor BIOS, FM BIOS)
// into RAM one byte at a time, holding the rest of the cartridge off until done.
module flash_loader #(
    parameter bit          ENABLE_MEGAROM     = 1'b1,
    parameter bit          ENABLE_NEXTOR      = 1'b1,
    parameter bit          ENABLE_FM          = 1'b1,
    parameter logic [23:0] MEGAROM_FLASH_BASE = 24'h200000,
    parameter logic [23:0] MEGAROM_SIZE       = 24'h200000,
    parameter logic [23:0] MEGAROM_RAM_BASE   = 24'h400000,
    parameter logic [23:0] NEXTOR_FLASH_BASE  = 24'h100000,
    parameter logic [23:0] NEXTOR_SIZE        = 24'h020000,
    parameter logic [23:0] NEXTOR_RAM_BASE    = 24'h700000,
    parameter logic [23:0] FM_FLASH_BASE      = 24'h120000,
    parameter logic [23:0] FM_SIZE            = 24'h004000,
    parameter logic [23:0] FM_RAM_BASE        = 24'h720000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        FLASH_REQ,
    output logic [23:0] FLASH_ADDR,
    input  logic        FLASH_ACK,
    input  logic        FLASH_RVALID,
    input  logic [7:0]  FLASH_RDATA,
    output logic        RAM_WE,
    output logic [23:0] RAM_ADDR,
    output logic [7:0]  RAM_WDATA,
    input  logic        RAM_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic [1:0]  REGION,
    output logic [2:0]  DBG_STATE
);

    // Handshakes: FLASH_REQ (with FLASH_ADDR) and RAM_WE (with RAM_ADDR/RAM_WDATA) are
    // held stable until the matching ACK is sampled high on a rising CLK edge; at most one
    // transfer is in flight and the two requests are never high together. FLASH_RVALID is
    // only honoured once the read was accepted; any ACK/RVALID in another state is ignored.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR      = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    localparam logic [1:0] REGION_NONE = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  region_q, region_d;
    logic [23:0] src_q, src_d;
    logic [23:0] dst_q, dst_d;
    logic [24:0] cnt_q, cnt_d;
    logic [7:0]  buf_q, buf_d;

    logic        pick_en;
    logic [23:0] pick_src;
    logic [23:0] pick_dst;
    logic [23:0] pick_size;

    // Region table, indexed by the SELECT scan position
    always_comb begin
        pick_en   = 1'b0;
        pick_src  = 24'h0;
        pick_dst  = 24'h0;
        pick_size = 24'h0;
        case (sel_q)
            2'd0: begin
                pick_en   = ENABLE_MEGAROM;
                pick_src  = MEGAROM_FLASH_BASE;
                pick_dst  = MEGAROM_RAM_BASE;
                pick_size = MEGAROM_SIZE;
            end
            2'd1: begin
                pick_en   = ENABLE_NEXTOR;
                pick_src  = NEXTOR_FLASH_BASE;
                pick_dst  = NEXTOR_RAM_BASE;
                pick_size = NEXTOR_SIZE;
            end
            2'd2: begin
                pick_en   = ENABLE_FM;
                pick_src  = FM_FLASH_BASE;
                pick_dst  = FM_RAM_BASE;
                pick_size = FM_SIZE;
            end
            default: begin
                pick_en   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        region_d = region_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        case (state_q)
            ST_IDLE: begin
                sel_d   = 2'd0;
                state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (sel_q == 2'd3) begin
                    region_d = REGION_NONE;
                    state_d  = ST_FINISH;
                end else begin
                    sel_d = sel_q + 2'd1;
                    if (pick_en && (pick_size != 24'h0)) begin
                        region_d = sel_q;
                        src_d    = pick_src;
                        dst_d    = pick_dst;
                        cnt_d    = {1'b0, pick_size};
                        state_d  = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (FLASH_ACK) begin
                    // Data returned with the accept skips RD_WAIT entirely
                    if (FLASH_RVALID) begin
                        buf_d   = FLASH_RDATA;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (FLASH_RVALID) begin
                    buf_d   = FLASH_RDATA;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (RAM_ACK) begin
                    src_d   = src_q + 24'd1;
                    dst_d   = dst_q + 24'd1;
                    cnt_d   = cnt_q - 25'd1;
                    state_d = (cnt_q == 25'd1) ? ST_SELECT : ST_RD_REQ;
                end
            end
            ST_FINISH: begin
                state_d = ST_FINISH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            region_q <= REGION_NONE;
            src_q    <= 24'h0;
            dst_q    <= 24'h0;
            cnt_q    <= 25'h0;
            buf_q    <= 8'h0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            region_q <= region_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
        end
    end

    assign FLASH_REQ  = (state_q == ST_RD_REQ);
    assign FLASH_ADDR = src_q;
    assign RAM_WE     = (state_q == ST_WR);
    assign RAM_ADDR   = dst_q;
    assign RAM_WDATA  = buf_q;
    assign BUSY       = (state_q != ST_FINISH);
    assign DONE       = (state_q == ST_FINISH);
    assign REGION     = region_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: a zero-wait instance with same-cycle read data (MegaROM off,
// FM empty) and a main instance exercised zero-wait, with random stalls and a mid-copy reset.
module tb_flash_loader;

    localparam logic [23:0] M_FL  = 24'h200000, M_SZ = 24'h000130, M_RAM = 24'h400000;
    localparam logic [23:0] N_FL  = 24'hFFFFFE, N_SZ = 24'h000004, N_RAM = 24'h700000;
    localparam logic [23:0] F_FL  = 24'h120000, F_SZ = 24'h000008, F_RAM = 24'h720000;
    localparam logic [23:0] BN_FL = 24'h100000, BN_SZ = 24'h000010, BN_RAM = 24'h700000;

    logic clk = 1'b0;
    logic rst, b_rst;

    logic        flash_req, flash_ack, flash_rvalid, ram_we, ram_ack, busy, done;
    logic [23:0] flash_addr, ram_addr;
    logic [7:0]  flash_rdata, ram_wdata;
    logic [1:0]  region;
    logic [2:0]  dbg_state;

    logic        b_flash_req, b_flash_ack, b_flash_rvalid, b_ram_we, b_ram_ack, b_busy, b_done;
    logic [23:0] b_flash_addr, b_ram_addr;
    logic [7:0]  b_flash_rdata, b_ram_wdata;
    logic [1:0]  b_region;
    logic [2:0]  b_dbg_state;

    logic [33:0] exp_q[$];
    logic [33:0] b_q[$];
    logic [23:0] fl_q[$];

    int n_vec = 0;
    int n_err = 0;
    int stall_max = 0;
    int rv_min = 1;
    bit spur_en = 1'b0;

    always #5 clk = ~clk;

    flash_loader #(
        .MEGAROM_FLASH_BASE(M_FL), .MEGAROM_SIZE(M_SZ), .MEGAROM_RAM_BASE(M_RAM),
        .NEXTOR_FLASH_BASE(N_FL),  .NEXTOR_SIZE(N_SZ),  .NEXTOR_RAM_BASE(N_RAM),
        .FM_FLASH_BASE(F_FL),      .FM_SIZE(F_SZ),      .FM_RAM_BASE(F_RAM)
    ) dut (
        .CLK(clk), .RESET(rst),
        .FLASH_REQ(flash_req), .FLASH_ADDR(flash_addr), .FLASH_ACK(flash_ack),
        .FLASH_RVALID(flash_rvalid), .FLASH_RDATA(flash_rdata),
        .RAM_WE(ram_we), .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata), .RAM_ACK(ram_ack),
        .BUSY(busy), .DONE(done), .REGION(region), .DBG_STATE(dbg_state)
    );

    flash_loader #(
        .ENABLE_MEGAROM(1'b0),
        .NEXTOR_FLASH_BASE(BN_FL), .NEXTOR_SIZE(BN_SZ), .NEXTOR_RAM_BASE(BN_RAM),
        .FM_SIZE(24'h0)
    ) dut_b (
        .CLK(clk), .RESET(b_rst),
        .FLASH_REQ(b_flash_req), .FLASH_ADDR(b_flash_addr), .FLASH_ACK(b_flash_ack),
        .FLASH_RVALID(b_flash_rvalid), .FLASH_RDATA(b_flash_rdata),
        .RAM_WE(b_ram_we), .RAM_ADDR(b_ram_addr), .RAM_WDATA(b_ram_wdata), .RAM_ACK(b_ram_ack),
        .BUSY(b_busy), .DONE(b_done), .REGION(b_region), .DBG_STATE(b_dbg_state)
    );

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic check_val(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_region(input logic [1:0] r, input logic [23:0] fl, input logic [23:0] sz,
                               input logic [23:0] ram);
        logic [23:0] s;
        logic [23:0] d;
        for (int i = 0; i < int'(sz); i++) begin
            s = fl + 24'(i);
            d = ram + 24'(i);
            fl_q.push_back(s);
            exp_q.push_back({r, d, flash_byte(s)});
        end
    endtask

    task automatic build_expected();
        exp_q.delete();
        fl_q.delete();
        push_region(2'd0, M_FL, M_SZ, M_RAM);
        push_region(2'd1, N_FL, N_SZ, N_RAM);
        push_region(2'd2, F_FL, F_SZ, F_RAM);
    endtask

    // Flash model for the main instance: random accept and data latency, optional noise
    initial begin : flash_side
        bit seen, pend;
        int aw, rw;
        logic [23:0] ra, la;
        flash_ack = 1'b0; flash_rvalid = 1'b0; flash_rdata = 8'h0;
        seen = 1'b0; pend = 1'b0; aw = 0; rw = 0; ra = 24'h0; la = 24'h0;
        forever begin
            @(negedge clk);
            flash_ack = 1'b0;
            flash_rvalid = 1'b0;
            if (rst) begin
                seen = 1'b0;
                pend = 1'b0;
            end else if (pend) begin
                rw--;
                if (rw == 0) begin
                    flash_rvalid = 1'b1;
                    flash_rdata = flash_byte(ra);
                    pend = 1'b0;
                end
            end else if (flash_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    la = flash_addr;
                    aw = int'($urandom_range(stall_max, 0));
                end else begin
                    check_val("flash_addr_held", 34'(flash_addr), 34'(la));
                end
                if (aw == 0) begin
                    flash_ack = 1'b1;
                    seen = 1'b0;
                    if (fl_q.size() == 0) check_val("flash_read_expected", 34'd0, 34'd1);
                    else check_val("flash_read_addr", 34'(flash_addr), 34'(fl_q.pop_front()));
                    rw = rv_min + int'($urandom_range(stall_max, 0));
                    if (rw == 0) begin
                        flash_rvalid = 1'b1;
                        flash_rdata = flash_byte(flash_addr);
                    end else begin
                        pend = 1'b1;
                        ra = flash_addr;
                    end
                end else begin
                    aw--;
                end
            end else if (spur_en && ram_we && ($urandom_range(3, 0) == 0)) begin
                flash_ack = 1'b1;
                flash_rvalid = 1'b1;
                flash_rdata = 8'($urandom);
            end
        end
    end

    // RAM model for the main instance: scoreboard pop on every accepted write
    initial begin : ram_side
        bit seen;
        int ww;
        logic [31:0] held;
        ram_ack = 1'b0; seen = 1'b0; ww = 0; held = 32'h0;
        forever begin
            @(negedge clk);
            ram_ack = 1'b0;
            if (rst) begin
                seen = 1'b0;
            end else if (ram_we) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = {ram_addr, ram_wdata};
                    ww = int'($urandom_range(stall_max, 0));
                end else begin
                    check_val("ram_held", 34'({ram_addr, ram_wdata}), 34'(held));
                end
                if (ww == 0) begin
                    ram_ack = 1'b1;
                    seen = 1'b0;
                    if (exp_q.size() == 0) check_val("ram_write_expected", 34'd0, 34'd1);
                    else check_val("ram_write", {region, ram_addr, ram_wdata}, exp_q.pop_front());
                end else begin
                    ww--;
                end
            end else if (spur_en && flash_req && ($urandom_range(3, 0) == 0)) begin
                ram_ack = 1'b1;
            end
        end
    end

    // Zero-wait memories for dut_b: read data returned together with the accept
    initial begin : b_side
        b_flash_ack = 1'b0; b_flash_rvalid = 1'b0; b_flash_rdata = 8'h0; b_ram_ack = 1'b0;
        forever begin
            @(negedge clk);
            b_flash_ack = b_flash_req;
            b_flash_rvalid = b_flash_req;
            b_flash_rdata = flash_byte(b_flash_addr);
            b_ram_ack = b_ram_we;
            if (b_ram_we && !b_rst) begin
                if (b_q.size() == 0) check_val("b_ram_write_expected", 34'd0, 34'd1);
                else check_val("b_ram_write", {b_region, b_ram_addr, b_ram_wdata}, b_q.pop_front());
            end
        end
    end

    initial begin : main_seq
        int cycles;
        bit found;
        rst = 1'b1;
        b_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_flash_req", 34'(flash_req), 34'd0);
        check_val("rst_flash_addr", 34'(flash_addr), 34'd0);
        check_val("rst_ram_we", 34'(ram_we), 34'd0);
        check_val("rst_ram_addr", 34'(ram_addr), 34'd0);
        check_val("rst_ram_wdata", 34'(ram_wdata), 34'd0);
        check_val("rst_busy", 34'(busy), 34'd1);
        check_val("rst_done", 34'(done), 34'd0);
        check_val("rst_region", 34'(region), 34'd3);
        check_val("rst_state", 34'(dbg_state), 34'd0);

        // dut_b: Nextor only, 16 bytes, two cycles per byte
        b_q.delete();
        for (int i = 0; i < int'(BN_SZ); i++)
            b_q.push_back({2'd1, BN_RAM + 24'(i), flash_byte(BN_FL + 24'(i))});
        b_rst = 1'b0;
        cycles = 0;
        while (!b_done && cycles < 500) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_val("b_done_cycles", 34'(cycles), 34'd37);
        check_val("b_writes_left", 34'(b_q.size()), 34'd0);
        check_val("b_region_final", 34'(b_region), 34'd3);
        check_val("b_busy_final", 34'(b_busy), 34'd0);

        // Main instance, zero-wait memories, three cycles per byte
        build_expected();
        stall_max = 0;
        rv_min = 1;
        spur_en = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_one_cycle", 34'(dbg_state), 34'd1);
        check_val("idle_busy", 34'(busy), 34'd1);
        cycles = 1;
        while (!done && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_val("a_done_cycles", 34'(cycles), 34'd953);
        check_val("a_writes_left", 34'(exp_q.size()), 34'd0);
        check_val("a_reads_left", 34'(fl_q.size()), 34'd0);
        check_val("a_region_final", 34'(region), 34'd3);
        check_val("a_busy_final", 34'(busy), 34'd0);
        check_val("a_outputs_idle", 34'({flash_req, ram_we}), 34'd0);
        repeat (4) @(posedge clk);
        #1;
        check_val("a_done_sticky", 34'({done, dbg_state}), 34'({1'b1, 3'd5}));

        // Random stalls and noise, reset while 0x400123 is being written
        rst = 1'b1;
        stall_max = 7;
        rv_min = 0;
        spur_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        build_expected();
        rst = 1'b0;
        found = 1'b0;
        cycles = 0;
        while (!found && cycles < 20000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (ram_we && ram_addr == 24'h400123) found = 1'b1;
        end
        check_val("reached_0x400123", 34'(found), 34'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_drops_ram_we", 34'(ram_we), 34'd0);
        check_val("reset_region", 34'(region), 34'd3);
        @(posedge clk);
        #1;
        build_expected();
        rst = 1'b0;
        cycles = 0;
        while (!done && cycles < 40000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_val("b_phase_done", 34'(done), 34'd1);
        check_val("b_phase_writes_left", 34'(exp_q.size()), 34'd0);
        check_val("b_phase_reads_left", 34'(fl_q.size()), 34'd0);
        check_val("b_phase_busy", 34'(busy), 34'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 Parameter ENABLE_MEGAROM, default 1, copy the MegaROM region when 1.
REQ-002 Parameter ENABLE_NEXTOR, default 1, copy the Nextor BIOS region when 1.
REQ-003 Parameter ENABLE_FM, default 1, copy the FM BIOS region when 1.
REQ-004 Parameters for region base/size, all 24-bit, with these defaults:
- MegaROM: flash 0x200000, size 0x200000, RAM 0x400000.
- Nextor: flash 0x100000, size 0x020000, RAM 0x700000.
- FM: flash 0x120000, size 0x004000, RAM 0x720000.
REQ-005 Port CLK, input, 1, the single system clock; reset is synchronous and active-high.
REQ-006 Port RESET, input, 1, synchronous active-high reset, sampled on the CLK rising edge.
REQ-007 Port FLASH_REQ, output, 1, flash byte-read request; held until accepted.
REQ-008 Port FLASH_ADDR, output, 24, flash byte address; stable while FLASH_REQ=1.
REQ-009 Port FLASH_ACK, input, 1, flash accepted the request this cycle.
REQ-010 Port FLASH_RVALID, input, 1, FLASH_RDATA valid this cycle; one pulse per accepted request.
REQ-011 Port FLASH_RDATA, input, 8, read byte.
REQ-012 Port RAM_WE, output, 1, RAM byte-write request; held until acknowledged.
REQ-013 Port RAM_ADDR, output, 24, RAM byte address; stable while RAM_WE=1.
REQ-014 Port RAM_WDATA, output, 8, write byte; stable while RAM_WE=1.
REQ-015 Port RAM_ACK, input, 1, RAM completed the write this cycle.
REQ-016 Port BUSY, output, 1, copy in progress; the rest of the cartridge is held off while 1.
REQ-017 Port DONE, output, 1, all enabled regions copied; sticky until reset.
REQ-018 Port REGION, output, 2, index of the active region: 0 = MegaROM, 1 = Nextor, 2 = FM, 3 = none.

Function
REQ-019 States SHALL be IDLE, SELECT, RD_REQ, RD_WAIT, WR, FINISH.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to SELECT.
REQ-021 SELECT SHALL pick regions in order 0 -> 1 -> 2, skipping any region whose enable is 0 or whose size is 0, in one cycle per step.
- On picking a region: load the source/destination pointers and the remaining count (= size); go to RD_REQ.
- With no region left: go to FINISH.
REQ-022 RD_REQ: FLASH_REQ=1 and FLASH_ADDR=source pointer.
- FLASH_ACK=1: go to RD_WAIT, deasserting FLASH_REQ the following cycle.
REQ-023 RD_WAIT: on FLASH_RVALID=1, latch FLASH_RDATA into the single-byte buffer and go to WR.
- FLASH_RVALID in the same cycle as FLASH_ACK: capture it and go straight to WR, skipping RD_WAIT.
REQ-024 WR: RAM_WE=1, RAM_ADDR=destination pointer, RAM_WDATA=buffer.
- RAM_ACK=1: increment both pointers by 1 and decrement the count by 1.
- Count was 1: go to SELECT for the next region; otherwise go to RD_REQ.
REQ-025 Pointers SHALL be 24-bit and wrap modulo 2^24; a wrap SHALL NOT flag an error.
REQ-026 The count SHALL be 25-bit so that a size of 0x1000000 is representable.
REQ-027 At most one flash request and one RAM write SHALL be outstanding; FLASH_REQ and RAM_WE are never both 1.
REQ-028 FINISH: DONE=1, BUSY=0, REGION=3, FLASH_REQ=0, RAM_WE=0; the state is terminal until reset.
REQ-029 BUSY SHALL be 1 in every state except FINISH, including IDLE.
REQ-030 Throughput with a zero-wait flash and RAM SHALL be one byte per 3 cycles (RD_REQ, RD_WAIT, WR).
REQ-031 FLASH_ACK, FLASH_RVALID or RAM_ACK arriving in a state that does not expect it SHALL be ignored.

Reset
REQ-032 On RESET=1 every output SHALL take its reset value on the next CLK edge:
- FLASH_REQ=0, FLASH_ADDR=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0.
- BUSY=1, DONE=0, REGION=3; state=IDLE.
REQ-033 Reset asserted mid-copy SHALL abandon any outstanding transaction and restart the whole copy from region 0 after release.

Verification
REQ-034 Defaults, zero-wait memories -> bytes written in order:
- 0x400000..0x5FFFFF from 0x200000..
- then 0x700000..0x71FFFF from 0x100000..
- then 0x720000..0x723FFF from 0x120000..
- DONE rises 3*0x224000 + 3 (SELECT steps) + 1 cycles after reset release (within ±2).
REQ-035 ENABLE_MEGAROM=0, Nextor size 0x10, FM size 0 -> exactly 16 RAM writes to 0x700000..0x70000F, REGION 1 then 3, DONE=1.
REQ-036 Random 0-7 cycle stalls on FLASH_ACK, FLASH_RVALID and RAM_ACK -> the RAM image matches the flash image and addresses/data stay stable while a request is held.
REQ-037 RESET pulsed while the MegaROM byte at 0x400123 is in WR -> RAM_WE=0 next cycle; after release the copy restarts at flash 0x200000 and completes.
REQ-038 Nextor flash base 0xFFFFFE, size 4 -> flash reads 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001 with no error and DONE asserts.
REQ-039 FLASH_ACK and FLASH_RVALID asserted in the same cycle -> byte captured, WR entered next cycle, no double write.
